// File: rtl/pspin_pkt_dma_ctrl.sv
// pspin_pkt_dma_ctrl: turns allocator write commands into DMA descriptors and retires
// completed transfers in command order as handler requests, or as slot frees on DMA error.
module pspin_pkt_dma_ctrl #(
   parameter int ADDR_WIDTH    = 32,
   parameter int LEN_WIDTH     = 20,
   parameter int TAG_WIDTH     = 32,
   parameter int MSGID_WIDTH   = 10,
   parameter int DMA_TAG_WIDTH = 4,
   parameter int ERR_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]     cmd_len_i,
   input  logic [TAG_WIDTH-1:0]     cmd_tag_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   output logic [ADDR_WIDTH-1:0]    desc_addr_o,
   output logic [LEN_WIDTH-1:0]     desc_len_o,
   output logic [DMA_TAG_WIDTH-1:0] desc_tag_o,
   output logic                     desc_valid_o,
   input  logic                     desc_ready_i,
   input  logic [DMA_TAG_WIDTH-1:0] stat_tag_i,
   input  logic [ERR_WIDTH-1:0]     stat_err_i,
   input  logic                     stat_valid_i,
   output logic [ADDR_WIDTH-1:0]    her_addr_o,
   output logic [LEN_WIDTH-1:0]     her_size_o,
   output logic [MSGID_WIDTH-1:0]   her_msgid_o,
   output logic [TAG_WIDTH-1:0]     her_tag_o,
   output logic                     her_valid_o,
   input  logic                     her_ready_i,
   output logic [ADDR_WIDTH-1:0]    free_addr_o,
   output logic [LEN_WIDTH-1:0]     free_size_o,
   output logic                     free_valid_o,
   input  logic                     free_ready_i,
   output logic [31:0]              dma_err_cnt_o,
   output logic [31:0]              bad_stat_cnt_o
);
   localparam int DEPTH = 2**DMA_TAG_WIDTH;
   localparam int CW    = DMA_TAG_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SEND_HER, SEND_FREE} state_t;

   state_t                   state;
   logic [ADDR_WIDTH-1:0]    e_addr [DEPTH];
   logic [LEN_WIDTH-1:0]     e_len  [DEPTH];
   logic [TAG_WIDTH-1:0]     e_tag  [DEPTH];
   logic [DEPTH-1:0]         e_valid, e_done, e_err;
   logic [DMA_TAG_WIDTH-1:0] head, tail;
   logic [CW-1:0]            count;
   logic                     cmd_fire, retire, stat_hit;

   // count never exceeds DEPTH, so its MSB alone flags a full table
   assign cmd_ready_o = !count[CW-1] && (!desc_valid_o || desc_ready_i);
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;
   assign retire      = (her_valid_o && her_ready_i) || (free_valid_o && free_ready_i);
   assign stat_hit    = e_valid[stat_tag_i] && !e_done[stat_tag_i];

   always_ff @(posedge clk) begin
      if (cmd_fire) begin
         e_addr[tail] <= cmd_addr_i;
         e_len[tail]  <= cmd_len_i;
         e_tag[tail]  <= cmd_tag_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         e_valid <= '0;
         e_done  <= '0;
         e_err   <= '0;
      end else begin
         if (cmd_fire) begin
            e_valid[tail] <= 1'b1;
            e_done[tail]  <= 1'b0;
            e_err[tail]   <= 1'b0;
         end
         if (stat_valid_i && stat_hit) begin
            e_done[stat_tag_i] <= 1'b1;
            e_err[stat_tag_i]  <= |stat_err_i;
         end
         if (retire) e_valid[head] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         desc_valid_o <= 1'b0;
         desc_addr_o  <= '0;
         desc_len_o   <= '0;
         desc_tag_o   <= '0;
         tail         <= '0;
      end else if (cmd_fire) begin
         desc_valid_o <= 1'b1;
         desc_addr_o  <= cmd_addr_i;
         desc_len_o   <= cmd_len_i;
         desc_tag_o   <= tail;
         tail         <= tail + DMA_TAG_WIDTH'(1);
      end else if (desc_ready_i) begin
         desc_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) count <= '0;
      else count <= count + CW'(cmd_fire) - CW'(retire);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dma_err_cnt_o  <= '0;
         bad_stat_cnt_o <= '0;
      end else if (stat_valid_i) begin
         if (!stat_hit) bad_stat_cnt_o <= bad_stat_cnt_o + 32'd1;
         else if (|stat_err_i) dma_err_cnt_o <= dma_err_cnt_o + 32'd1;
      end
   end

   // retire only the head entry, so requests leave in command order
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         head         <= '0;
         her_valid_o  <= 1'b0;
         her_addr_o   <= '0;
         her_size_o   <= '0;
         her_msgid_o  <= '0;
         her_tag_o    <= '0;
         free_valid_o <= 1'b0;
         free_addr_o  <= '0;
         free_size_o  <= '0;
      end else begin
         case (state)
            IDLE: if (e_valid[head] && e_done[head]) begin
               her_addr_o   <= e_addr[head];
               her_size_o   <= e_len[head];
               her_msgid_o  <= e_tag[head][MSGID_WIDTH-1:0];
               her_tag_o    <= e_tag[head];
               free_addr_o  <= e_addr[head];
               free_size_o  <= e_len[head];
               her_valid_o  <= !e_err[head];
               free_valid_o <= e_err[head];
               state        <= e_err[head] ? SEND_FREE : SEND_HER;
            end
            SEND_HER: if (her_ready_i) begin
               her_valid_o <= 1'b0;
               head        <= head + DMA_TAG_WIDTH'(1);
               state       <= IDLE;
            end
            SEND_FREE: if (free_ready_i) begin
               free_valid_o <= 1'b0;
               head         <= head + DMA_TAG_WIDTH'(1);
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pspin_pkt_dma_ctrl.sv
// tb_pspin_pkt_dma_ctrl: directed and random checks of the DMA controller against an
// in-order queue model of outstanding commands.
module tb_pspin_pkt_dma_ctrl;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [19:0] cmd_len = '0;
   logic [31:0] cmd_tag = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready_o;
   logic [31:0] desc_addr_o;
   logic [19:0] desc_len_o;
   logic [3:0]  desc_tag_o;
   logic        desc_valid_o;
   logic        desc_ready = 1'b1;
   logic [3:0]  stat_tag = '0;
   logic [3:0]  stat_err = '0;
   logic        stat_valid = 1'b0;
   logic [31:0] her_addr_o;
   logic [19:0] her_size_o;
   logic [9:0]  her_msgid_o;
   logic [31:0] her_tag_o;
   logic        her_valid_o;
   logic        her_ready = 1'b1;
   logic [31:0] free_addr_o;
   logic [19:0] free_size_o;
   logic        free_valid_o;
   logic        free_ready = 1'b1;
   logic [31:0] dma_err_cnt_o, bad_stat_cnt_o;

   pspin_pkt_dma_ctrl dut (
      .clk(clk), .rstn(rstn),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_tag_i(cmd_tag),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
      .desc_addr_o(desc_addr_o), .desc_len_o(desc_len_o), .desc_tag_o(desc_tag_o),
      .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready),
      .stat_tag_i(stat_tag), .stat_err_i(stat_err), .stat_valid_i(stat_valid),
      .her_addr_o(her_addr_o), .her_size_o(her_size_o), .her_msgid_o(her_msgid_o),
      .her_tag_o(her_tag_o), .her_valid_o(her_valid_o), .her_ready_i(her_ready),
      .free_addr_o(free_addr_o), .free_size_o(free_size_o),
      .free_valid_o(free_valid_o), .free_ready_i(free_ready),
      .dma_err_cnt_o(dma_err_cnt_o), .bad_stat_cnt_o(bad_stat_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [19:0] len;
      logic [31:0] tag;
      logic [3:0]  dt;
      bit          done;
      bit          err;
   } ent_t;

   ent_t        q[$];
   int          tests = 0, fails = 0;
   int          issued = 0, errs = 0, bads = 0, nher = 0, nfree = 0;
   bit          exp_dv = 0, last_fire = 0;
   logic [31:0] exp_da;
   logic [19:0] exp_dl;
   logic [3:0]  exp_dt;

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
      end
   endtask

   // one clock: check outputs against the model, then apply what fired at the edge
   task automatic tick();
      bit cf, hf, ff, hit;
      #1;
      chk("cmd_ready", cmd_ready_o, (q.size() < 16) && (!exp_dv || desc_ready));
      chk("desc_valid", desc_valid_o, exp_dv);
      if (exp_dv) begin
         chk("desc_addr", desc_addr_o, exp_da);
         chk("desc_len", desc_len_o, exp_dl);
         chk("desc_tag", desc_tag_o, exp_dt);
      end
      chk("dma_err_cnt", dma_err_cnt_o, errs);
      chk("bad_stat_cnt", bad_stat_cnt_o, bads);
      chk("her_free_excl", her_valid_o && free_valid_o, 0);
      if (her_valid_o) begin
         chk("her_head_ok", (q.size() > 0) && q[0].done && !q[0].err, 1);
         if (q.size() > 0) begin
            chk("her_addr", her_addr_o, q[0].addr);
            chk("her_size", her_size_o, q[0].len);
            chk("her_msgid", her_msgid_o, q[0].tag[9:0]);
            chk("her_tag", her_tag_o, q[0].tag);
         end
      end
      if (free_valid_o) begin
         chk("free_head_err", (q.size() > 0) && q[0].done && q[0].err, 1);
         if (q.size() > 0) begin
            chk("free_addr", free_addr_o, q[0].addr);
            chk("free_size", free_size_o, q[0].len);
         end
      end
      cf = cmd_valid && cmd_ready_o;
      hf = her_valid_o && her_ready;
      ff = free_valid_o && free_ready;
      @(posedge clk);
      if (stat_valid) begin
         hit = 0;
         foreach (q[i]) if (q[i].dt == stat_tag && !q[i].done) begin
            q[i].done = 1;
            q[i].err = (stat_err != 0);
            hit = 1;
         end
         if (!hit) bads++;
         else if (stat_err != 0) errs++;
      end
      if (hf || ff) void'(q.pop_front());
      if (hf) nher++;
      if (ff) nfree++;
      if (desc_ready) exp_dv = 0;
      if (cf) begin
         q.push_back('{addr: cmd_addr, len: cmd_len, tag: cmd_tag, dt: 4'(issued), done: 0, err: 0});
         exp_dv = 1;
         exp_da = cmd_addr;
         exp_dl = cmd_len;
         exp_dt = 4'(issued);
         issued++;
      end
      last_fire = cf;
      @(negedge clk);
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [19:0] l, input logic [31:0] t);
      cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_tag = t;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (last_fire) break;
      end
      chk("cmd_accept", last_fire, 1);
      cmd_valid = 0;
   endtask

   task automatic send_stat(input logic [3:0] t, input logic [3:0] e);
      stat_valid = 1; stat_tag = t; stat_err = e;
      tick();
      stat_valid = 0;
   endtask

   task automatic wait_her();
      for (int i = 0; i < 30 && !her_valid_o; i++) tick();
      chk("wait_her", her_valid_o, 1);
   endtask

   task automatic do_reset();
      #2 rstn = 0;
      #1;
      chk("rst_her_valid", her_valid_o, 0);
      chk("rst_free_valid", free_valid_o, 0);
      chk("rst_desc_valid", desc_valid_o, 0);
      chk("rst_count", dut.count, 0);
      chk("rst_counters", {dma_err_cnt_o, bad_stat_cnt_o}, 0);
      q.delete();
      issued = 0; errs = 0; bads = 0; exp_dv = 0;
      cmd_valid = 0; stat_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1;
   endtask

   task automatic drain();
      int k;
      cmd_valid = 0; desc_ready = 1; her_ready = 1; free_ready = 1;
      for (int n = 0; n < 40; n++) begin
         k = -1;
         foreach (q[i]) if (k < 0 && !q[i].done) k = i;
         if (k < 0) break;
         send_stat(q[k].dt, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
      for (int i = 0; i < 100 && q.size() > 0; i++) tick();
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] watchdog expired: FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int h0;
      logic [31:0] sa, st;
      logic [19:0] sl;
      @(negedge clk);
      do_reset();
      chk("reset_ready", cmd_ready_o, 1);

      // single command, successful completion
      her_ready = 0;
      send_cmd(32'h1c100000, 20'd1536, 32'h2A);
      chk("t1_desc_valid", desc_valid_o, 1);
      chk("t1_desc_addr", desc_addr_o, 32'h1c100000);
      chk("t1_desc_len", desc_len_o, 20'd1536);
      chk("t1_desc_tag", desc_tag_o, 0);
      send_stat(4'd0, 4'd0);
      wait_her();
      chk("t1_her_addr", her_addr_o, 32'h1c100000);
      chk("t1_her_size", her_size_o, 20'd1536);
      chk("t1_her_msgid", her_msgid_o, 10'h2A);
      chk("t1_her_tag", her_tag_o, 32'h2A);
      her_ready = 1;
      tick();
      chk("t1_nher", nher, 1);

      // out-of-order completions, in-order requests
      h0 = nher;
      for (int i = 0; i < 3; i++) send_cmd($urandom, 20'($urandom), 32'h100 + i);
      send_stat(4'(issued - 1), 4'd0);
      repeat (4) tick();
      chk("t2_none_early", nher, h0);
      send_stat(4'(issued - 3), 4'd0);
      send_stat(4'(issued - 2), 4'd0);
      drain();
      chk("t2_three_hers", nher - h0, 3);

      // DMA error frees the slot
      do_reset();
      free_ready = 0;
      send_cmd(32'h1c200040, 20'd512, 32'h77);
      send_stat(4'd0, 4'd3);
      for (int i = 0; i < 30 && !free_valid_o; i++) tick();
      chk("t3_free_valid", free_valid_o, 1);
      chk("t3_free_addr", free_addr_o, 32'h1c200040);
      chk("t3_free_size", free_size_o, 20'd512);
      chk("t3_no_her", her_valid_o, 0);
      chk("t3_err_cnt", dma_err_cnt_o, 1);
      free_ready = 1;
      tick();
      chk("t3_retired", q.size(), 0);

      // fill all 16 entries, then one retire reopens the table
      do_reset();
      for (int i = 0; i < 16; i++) send_cmd($urandom, 20'($urandom), $urandom);
      cmd_valid = 1;
      tick();
      chk("t4_full_block", last_fire, 0);
      chk("t4_full_ready", cmd_ready_o, 0);
      cmd_valid = 0;
      send_stat(4'd0, 4'd0);
      for (int i = 0; i < 20 && q.size() == 16; i++) tick();
      chk("t4_one_retired", q.size(), 15);
      chk("t4_ready_again", cmd_ready_o, 1);
      send_cmd(32'hdead0000, 20'd64, 32'h5);
      chk("t4_tail_wrap", desc_tag_o, 0);
      drain();

      // statuses for idle and already completed tags
      do_reset();
      her_ready = 0;
      send_stat(4'd5, 4'd0);
      chk("t5_quiet", {her_valid_o, free_valid_o, desc_valid_o}, 0);
      send_cmd($urandom, 20'($urandom), $urandom);
      send_stat(4'd0, 4'd0);
      send_stat(4'd0, 4'd0);
      tick();
      chk("t5_bad_cnt", bad_stat_cnt_o, 2);
      chk("t5_err_cnt", dma_err_cnt_o, 0);
      drain();

      // stalled HER holds steady, reset drops it
      do_reset();
      her_ready = 0;
      send_cmd($urandom, 20'($urandom), $urandom);
      send_stat(4'd0, 4'd0);
      wait_her();
      sa = her_addr_o; sl = her_size_o; st = her_tag_o;
      repeat (10) tick();
      chk("t6_still_valid", her_valid_o, 1);
      chk("t6_stable", {her_addr_o, her_size_o, her_tag_o}, {sa, sl, st});
      do_reset();
      her_ready = 1;
      tick();
      chk("t6_no_her", her_valid_o, 0);

      // random traffic against the queue model
      for (int n = 0; n < 400; n++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_addr = $urandom; cmd_len = 20'($urandom); cmd_tag = $urandom;
         desc_ready = ($urandom_range(0, 3) != 0);
         her_ready = ($urandom_range(0, 2) != 0);
         free_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 2) == 0) begin
            stat_valid = 1;
            stat_tag = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       q[$urandom_range(0, q.size() - 1)].dt : 4'($urandom);
            stat_err = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         end
         tick();
         stat_valid = 0;
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
